// File: rtl/resp_serializer.sv
// -----------------------------------------------------------------------------
// resp_serializer
//
// Purpose:
//   This block sits directly after the command dispatcher. Each response packet
//   arrives as a single-cycle strobe and is captured into a small circular
//   queue. The packet is then sent to the UART transmitter as a fixed byte
//   frame over a valid/ready byte handshake:
//     SYNC_BYTE, {6'b0, cmd_type}, addr, data [, checksum]
//   The dispatcher cannot be back-pressured. A packet that arrives while the
//   queue is full is dropped, and the drop is reported.
//
// Optional feature macro: RESP_CHECKSUM_EN
//   defined   : 5-byte frame. The last byte is the XOR of the four bytes
//               before it.
//   undefined : 4-byte frame. The checksum state is not built.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   pkt_in      in   response packet (cmd_type[1:0], addr[7:0], data[7:0])
//   pkt_valid   in   single-cycle capture strobe for pkt_in
//   tx_byte     out  byte to the UART transmitter
//   tx_valid    out  tx_byte is valid
//   tx_ready    in   transmitter accepts the byte (transfer = valid && ready)
//   busy        out  queue non-empty or a frame in progress
//   q_level     out  current queue occupancy, 0..DEPTH
//   overflow    out  one-cycle pulse after a packet was dropped
//   drop_count  out  saturating count of dropped packets
// -----------------------------------------------------------------------------

package resp_pkg;
    typedef struct packed {
        logic [1:0] cmd_type;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_packet_t;
endpackage

module resp_serializer
    import resp_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  cmd_packet_t              pkt_in,
    input  logic                     pkt_valid,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            LW       = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

`ifdef RESP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SYNC, S_TYPE, S_ADDR, S_DATA, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SYNC, S_TYPE, S_ADDR, S_DATA
    } state_t;
`endif

    // Queue storage and bookkeeping
    cmd_packet_t    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q,  level_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_q,   drop_d;

    // Frame FSM, its registered outputs, and the frame register
    state_t         state_q;
    logic [7:0]     tx_byte_q;
    logic           tx_valid_q;
    logic [1:0]     frm_type_q;
    logic [7:0]     frm_addr_q;
    logic [7:0]     frm_data_q;

    logic           q_full;
    logic           push;
    logic           drop;
    logic           pop;
    cmd_packet_t    head;

    // -------------------------------------------------------------------------
    // Queue next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Fullness comes from the registered level. A pop in the same cycle
        // does not make room for the incoming packet, so that packet is
        // dropped.
        q_full = (level_q == FULL_LVL);
        push   = pkt_valid && !q_full;
        drop   = pkt_valid && q_full;
        // Only IDLE pops, and IDLE always pops when anything is queued.
        pop    = (state_q == S_IDLE) && (level_q != '0);
        head   = mem_q[rd_ptr_q];

        // DEPTH is a power of two, so the pointers wrap without extra logic.
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        overflow_d = drop;
        drop_d     = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Packet storage is not reset. Entries are only read after a push has
    // written them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_in;
        end
    end

    // -------------------------------------------------------------------------
    // Frame FSM with registered tx_byte / tx_valid
    // -------------------------------------------------------------------------
    // The SYNC byte is presented in the same edge that pops the head entry.
    // This means LOAD is already the first cycle in which SYNC is offered. If
    // tx_ready is high in LOAD, the SYNC byte is accepted right away and the
    // FSM goes straight to TYPE. Otherwise it waits in SYNC with the byte
    // held. Every later state holds its byte until a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_byte_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        frm_type_q <= head.cmd_type;
                        frm_addr_q <= head.addr;
                        frm_data_q <= head.data;
                        tx_byte_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD, S_SYNC: begin
                    if (tx_ready) begin
                        tx_byte_q <= {6'b0, frm_type_q};
                        state_q   <= S_TYPE;
                    end else begin
                        state_q   <= S_SYNC;
                    end
                end
                S_TYPE: begin
                    if (tx_ready) begin
                        tx_byte_q <= frm_addr_q;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (tx_ready) begin
                        tx_byte_q <= frm_data_q;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_ready) begin
`ifdef RESP_CHECKSUM_EN
                        tx_byte_q <= SYNC_BYTE ^ {6'b0, frm_type_q}
                                     ^ frm_addr_q ^ frm_data_q;
                        state_q   <= S_CSUM;
`else
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
`endif
                    end
                end
`ifdef RESP_CHECKSUM_EN
                S_CSUM: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (level_q != '0) || (state_q != S_IDLE);
    assign q_level    = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_resp_serializer.sv
// -----------------------------------------------------------------------------
// tb_resp_serializer
//
// This bench keeps a reference model of the serializer built from two queues:
//   - the queue of accepted packets
//   - the byte list of the frame that is currently being sent.
// The model is updated once per clock edge from the inputs. The DUT outputs
// are compared against it after every edge. Directed scenarios also pin the
// byte sequences and the timing with literal values.
// -----------------------------------------------------------------------------
module tb_resp_serializer;
    import resp_pkg::*;

    localparam int         DEPTH = 4;
    localparam logic [7:0] SB    = 8'hA5;
`ifdef RESP_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic                     clk;
    logic                     rst;
    cmd_packet_t              pkt_in;
    logic                     pkt_valid;
    logic [7:0]               tx_byte;
    logic                     tx_valid;
    logic                     tx_ready;
    logic                     busy;
    logic [$clog2(DEPTH):0]   q_level;
    logic                     overflow;
    logic [7:0]               drop_count;

    resp_serializer #(.DEPTH(DEPTH), .SYNC_BYTE(SB)) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_in     (pkt_in),
        .pkt_valid  (pkt_valid),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .q_level    (q_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    cmd_packet_t m_q[$];
    logic [7:0]  m_frame[$];
    logic        m_ovf;
    int          m_drops;

    logic [7:0]  dut_log[$];   // bytes the DUT actually handed over
    int          checks;
    int          errors;
    int          cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_byte(input string nm, input int idx, input logic [7:0] e);
        logic [31:0] a;
        a = (idx < dut_log.size()) ? 32'(dut_log[idx]) : 32'hDEAD_BEEF;
        chk(nm, a, 32'(e));
    endtask

    // Advance the model by one clock edge. The inputs it reads are the values
    // that the edge samples.
    task automatic model_tick();
        logic        was_full;
        logic        idle;
        cmd_packet_t h;
        if (rst) begin
            m_q.delete();
            m_frame.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            was_full = (m_q.size() >= DEPTH);
            idle     = (m_frame.size() == 0);
            if (!idle && tx_ready) void'(m_frame.pop_front());
            if (idle && m_q.size() != 0) begin
                h = m_q.pop_front();
                m_frame.push_back(SB);
                m_frame.push_back({6'b0, h.cmd_type});
                m_frame.push_back(h.addr);
                m_frame.push_back(h.data);
`ifdef RESP_CHECKSUM_EN
                m_frame.push_back(SB ^ {6'b0, h.cmd_type} ^ h.addr ^ h.data);
`endif
            end
            m_ovf = pkt_valid && was_full;
            if (pkt_valid && !was_full) m_q.push_back(pkt_in);
            if (m_ovf && m_drops < 255) m_drops++;
        end
    endtask

    // One clock cycle. The caller sets the inputs at the negedge before it
    // calls step. step records a transfer if one is about to happen, updates
    // the model, waits for the edge, and compares all outputs at the next
    // negedge.
    task automatic step();
        if (!rst && tx_valid === 1'b1 && tx_ready) dut_log.push_back(tx_byte);
        model_tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("tx_valid", 32'(tx_valid), 32'(m_frame.size() != 0));
        if (m_frame.size() != 0) chk("tx_byte", 32'(tx_byte), 32'(m_frame[0]));
        chk("q_level", 32'(q_level), 32'(m_q.size()));
        chk("busy", 32'(busy), 32'((m_q.size() != 0) || (m_frame.size() != 0)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
    endtask

    task automatic wait_bytes(input int n, input int bound);
        for (int i = 0; i < bound && dut_log.size() < n; i++) step();
        chk("byte_count", 32'(dut_log.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pkt_valid = 1'b0;
        step();
        rst       = 1'b0;
        dut_log.delete();
    endtask

    task automatic push_pkt(input logic [17:0] p);
        pkt_in    = p;
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
    endtask

    initial begin
        logic [17:0] r;
        int          prate;
        int          rrate;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        pkt_valid = 1'b0;
        pkt_in    = '0;
        tx_ready  = 1'b0;
        step();
        step();
        chk("rst_tx_byte", 32'(tx_byte), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_q_level", 32'(q_level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_drop_count", 32'(drop_count), 32'h0);
        rst      = 1'b0;
        tx_ready = 1'b1;
        step();

        // Single packet with tx_ready tied high. Also checks latency.
        dut_log.delete();
        push_pkt({2'd0, 8'h10, 8'h3C});
        chk("lat_q_level_n1", 32'(q_level), 32'd1);
        chk("lat_tx_valid_n1", 32'(tx_valid), 32'd0);
        step();
        chk("lat_tx_valid_n2", 32'(tx_valid), 32'd1);
        chk("lat_sync_n2", 32'(tx_byte), 32'hA5);
        wait_bytes(FLEN, 20);
        chk("single_busy_end", 32'(busy), 32'd0);
        exp_byte("single_b0", 0, 8'hA5);
        exp_byte("single_b1", 1, 8'h00);
        exp_byte("single_b2", 2, 8'h10);
        exp_byte("single_b3", 3, 8'h3C);
`ifdef RESP_CHECKSUM_EN
        exp_byte("single_b4", 4, 8'h89);
`endif

        // Backpressure on the ADDR byte
        step();
        dut_log.delete();
        push_pkt({2'd2, 8'h5A, 8'hC3});
        wait_bytes(2, 20);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid_held", 32'(tx_valid), 32'd1);
            chk("bp_byte_held", 32'(tx_byte), 32'h5A);
        end
        tx_ready = 1'b1;
        wait_bytes(FLEN, 20);
        exp_byte("bp_b0", 0, 8'hA5);
        exp_byte("bp_b1", 1, 8'h02);
        exp_byte("bp_b2", 2, 8'h5A);
        exp_byte("bp_b3", 3, 8'hC3);
`ifdef RESP_CHECKSUM_EN
        exp_byte("bp_b4", 4, 8'h3E);
`endif

        // Overflow: six strobes with the transmitter stalled
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_pkt({2'(i), 8'(8'h20 + i), 8'(i * 3)});
            if (i == 4) chk("ovf_q_full", 32'(q_level), 32'd4);
        end
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        chk("ovf_q_level", 32'(q_level), 32'd4);
        step();
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        tx_ready = 1'b1;
        wait_bytes(5 * FLEN, 200);
        for (int k = 0; k < 5; k++) exp_byte("ovf_order", k * FLEN + 2, 8'(8'h20 + k));
        chk("ovf_busy_end", 32'(busy), 32'd0);

        // Pointer wrap-around: 10 packets at the drain rate
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_pkt({2'(i), 8'(i), 8'(255 - i)});
            repeat (FLEN - 1) step();
        end
        wait_bytes(10 * FLEN, 300);
        for (int k = 0; k < 10; k++) exp_byte("wrap_order", k * FLEN + 2, 8'(k));
        chk("wrap_no_drop", 32'(drop_count), 32'd0);

        // Full queue with a simultaneous IDLE pop
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pkt({2'd1, 8'(8'h40 + i), 8'h77});
        chk("fp_q_full", 32'(q_level), 32'd4);
        tx_ready = 1'b1;
        wait_bytes(FLEN, 20);
        push_pkt({2'd3, 8'hEE, 8'hEE});
        chk("fp_overflow", 32'(overflow), 32'd1);
        chk("fp_q_level", 32'(q_level), 32'(DEPTH - 1));
        chk("fp_drop_count", 32'(drop_count), 32'd1);
        chk("fp_popped", 32'(tx_valid), 32'd1);
        wait_bytes(5 * FLEN, 200);
        for (int k = 0; k < 5; k++) exp_byte("fp_order", k * FLEN + 2, 8'(8'h40 + k));

        // Reset in the middle of a frame (TYPE byte on the wire, 2 queued)
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pkt({2'(i + 1), 8'(8'h60 + i), 8'h11});
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("rm_type_byte", 32'(tx_byte), 32'h01);
        chk("rm_q_level", 32'(q_level), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_tx_valid", 32'(tx_valid), 32'd0);
        chk("rm_q_level0", 32'(q_level), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_drop_count", 32'(drop_count), 32'd0);
        dut_log.delete();
        tx_ready = 1'b1;
        repeat (20) step();
        chk("rm_no_residual", 32'(dut_log.size()), 32'd0);

        // drop_count saturates at 255
        do_reset();
        tx_ready  = 1'b0;
        pkt_in    = {2'd2, 8'h99, 8'h55};
        pkt_valid = 1'b1;
        repeat (270) step();
        pkt_valid = 1'b0;
        chk("sat_drop_count", 32'(drop_count), 32'd255);
        chk("sat_overflow", 32'(overflow), 32'd1);

        // Random traffic, checked cycle by cycle against the model
        do_reset();
        prate = 30;
        rrate = 60;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                prate = $urandom_range(5, 80);
                rrate = $urandom_range(10, 100);
            end
            r         = 18'($urandom);
            pkt_in    = r;
            pkt_valid = ($urandom_range(0, 99) < prate);
            tx_ready  = ($urandom_range(0, 99) < rrate);
            rst       = ($urandom_range(0, 599) == 0);
            step();
        end
        rst       = 1'b0;
        pkt_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
